gba_irq_ctrl: RTL and testbench

//  Interrupt controller downstream of the four timers and the other IRQ sources.

---
 rtl/gba_irq_ctrl_pkg.sv | 43 ++++
 rtl/gba_irq_ctrl_if.sv | 33 +++
 rtl/gba_irq_ctrl_edge_detect.sv | 48 ++++
 rtl/gba_irq_ctrl.sv | 108 ++++++++++
 tb/tb_gba_irq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/gba_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gba_irq_pkg
// Brief    : Shared types and constants for the GBA interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package gba_irq_pkg;

  localparam int IRQ_NUM_SRC = 14;

  typedef enum logic [3:0] {
    IRQ_VBLANK  = 4'd0,
    IRQ_HBLANK  = 4'd1,
    IRQ_VCOUNT  = 4'd2,
    IRQ_TIMER0  = 4'd3,
    IRQ_TIMER1  = 4'd4,
    IRQ_TIMER2  = 4'd5,
    IRQ_TIMER3  = 4'd6,
    IRQ_SERIAL  = 4'd7,
    IRQ_DMA0    = 4'd8,
    IRQ_DMA1    = 4'd9,
    IRQ_DMA2    = 4'd10,
    IRQ_DMA3    = 4'd11,
    IRQ_KEYPAD  = 4'd12,
    IRQ_GAMEPAK = 4'd13
  } irq_idx_e;

  // Offsets from the I/O base 0x0400_0000
  localparam logic [11:0] IRQ_IE_OFS  = 12'h200;
  localparam logic [11:0] IRQ_IF_OFS  = 12'h202;
  localparam logic [11:0] IRQ_IME_OFS = 12'h208;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } halt_state_e;

  function automatic logic [15:0] be_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gba_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : gba_irq_ctrl_if
// Brief    : Source, MMIO write/readback and CPU-side signals of the IRQ block.
// Revision : 1.0 - initial release
// ============================================================================
interface gba_irq_ctrl_if #(
  parameter int NUM_SRC = gba_irq_pkg::IRQ_NUM_SRC
);
  logic [NUM_SRC-1:0] irq_src;
  logic               wr_ie;
  logic               wr_if;
  logic               wr_ime;
  logic [15:0]        wr_data;
  logic [1:0]         wr_be;
  logic               halt_req;
  logic [15:0]        reg_IE;
  logic [15:0]        reg_IF;
  logic [15:0]        reg_IME;
  logic               irq;
  logic               halted;

  modport master (
    output irq_src, wr_ie, wr_if, wr_ime, wr_data, wr_be, halt_req,
    input  reg_IE, reg_IF, reg_IME, irq, halted
  );

  modport slave (
    input  irq_src, wr_ie, wr_if, wr_ime, wr_data, wr_be, halt_req,
    output reg_IE, reg_IF, reg_IME, irq, halted
  );
endinterface
`default_nettype wire

// File: rtl/gba_irq_ctrl_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : irq_edge_detect
// Brief    : Per-source history register and IRQ event generation.
// Revision : 1.0 - initial release
// ============================================================================
module irq_edge_detect #(
  parameter int NUM_SRC  = 14,
  parameter int SRC_EDGE = 1
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic [NUM_SRC-1:0] src,
  output logic      [NUM_SRC-1:0] ev
);

  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic               armed_q, armed_d;

  always_comb begin
    prev_d  = src;
    armed_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

  generate
    if (SRC_EDGE != 0) begin : g_edge
      // First cycle after reset only loads history, so a source already high
      // when reset drops is not mistaken for a fresh edge.
      assign ev = armed_q ? (src & ~prev_q) : '0;
    end else begin : g_level
      logic unused_hist;
      assign unused_hist = ^{prev_q, armed_q};
      assign ev          = src;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/gba_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gba_irq_ctrl
// Brief    : GBA IE/IF/IME registers, registered IRQ line and optional HALT gate.
//            Define GBA_IRQ_HALT_EN to build the RUN/HALT clock-gate FSM.
// Revision : 1.0 - initial release
// ============================================================================
module gba_irq_ctrl
  import gba_irq_pkg::*;
#(
  parameter int NUM_SRC  = IRQ_NUM_SRC,
  parameter int SRC_EDGE = 1
) (
  input wire logic      clock_16,
  input wire logic      reset,
  gba_irq_ctrl_if.slave bus
);

  logic [NUM_SRC-1:0] ev;
  logic [NUM_SRC-1:0] wr_mask, wr_val, clr;
  logic [NUM_SRC-1:0] ie_q, ie_d, if_q, if_d;
  logic               ime_q, ime_d, irq_q, irq_d;
  logic [15:0]        be_m;

  irq_edge_detect #(
    .NUM_SRC  (NUM_SRC),
    .SRC_EDGE (SRC_EDGE)
  ) u_edge (
    .clk (clock_16),
    .rst (reset),
    .src (bus.irq_src),
    .ev  (ev)
  );

  always_comb begin
    be_m    = be_mask(bus.wr_be);
    wr_mask = be_m[NUM_SRC-1:0];
    wr_val  = bus.wr_data[NUM_SRC-1:0] & wr_mask;
    clr     = bus.wr_if ? wr_val : '0;
    // New events win over a same-cycle write-1-to-clear
    if_d    = (if_q & ~clr) | ev;
    ie_d    = bus.wr_ie ? ((ie_q & ~wr_mask) | wr_val) : ie_q;
    ime_d   = (bus.wr_ime && bus.wr_be[0]) ? bus.wr_data[0] : ime_q;
    irq_d   = ime_q & (|(ie_q & if_q));
  end

  always_ff @(posedge clock_16) begin
    if (reset) begin
      ie_q  <= '0;
      if_q  <= '0;
      ime_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      if_q  <= if_d;
      ime_q <= ime_d;
      irq_q <= irq_d;
    end
  end

  assign bus.reg_IE  = 16'(ie_q);
  assign bus.reg_IF  = 16'(if_q);
  assign bus.reg_IME = {15'b0, ime_q};
  assign bus.irq     = irq_q;

  logic unused_wr;
  assign unused_wr = ^{be_m, bus.wr_data};

`ifdef GBA_IRQ_HALT_EN
  halt_state_e state_q;
  logic        halted_q;

  // Wake looks at next-cycle IF so halted drops on the edge the IF bit lands
  always_ff @(posedge clock_16) begin
    if (reset) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.halt_req) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (|(ie_q & if_d)) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.halted = halted_q;
`else
  logic unused_halt;
  assign unused_halt = bus.halt_req;
  assign bus.halted  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gba_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gba_irq_ctrl
// Brief    : Scoreboard bench for gba_irq_ctrl with directed latency checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gba_irq_ctrl;
  import gba_irq_pkg::*;

  localparam int NS = IRQ_NUM_SRC;

  logic clock_16 = 1'b0;
  logic reset    = 1'b1;

  always #5 clock_16 = ~clock_16;

  gba_irq_ctrl_if #(.NUM_SRC(NS)) bus ();

  gba_irq_ctrl #(
    .NUM_SRC  (NS),
    .SRC_EDGE (1)
  ) dut (
    .clock_16 (clock_16),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic [15:0] if_v;
    logic [15:0] ie_v;
    logic [15:0] ime_v;
    logic        irq;
    logic        halted;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [NS-1:0] m_prev = '0;
  logic [NS-1:0] m_if   = '0;
  logic [NS-1:0] m_ie   = '0;
  logic          m_arm  = 1'b0;
  logic          m_ime  = 1'b0;
  logic          m_irq  = 1'b0;
  logic          m_halt = 1'b0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: advance one clock from the inputs now on the bus
  task automatic model_push();
    exp_t          e;
    logic [15:0]   bm;
    logic [NS-1:0] msk, val, ev, clr, if_n;
    bm  = {{8{bus.wr_be[1]}}, {8{bus.wr_be[0]}}};
    msk = bm[NS-1:0];
    val = bus.wr_data[NS-1:0] & msk;
    ev  = m_arm ? (bus.irq_src & ~m_prev) : '0;
    if (reset) begin
      m_prev = '0; m_arm = 1'b0; m_if = '0; m_ie = '0;
      m_ime  = 1'b0; m_irq = 1'b0; m_halt = 1'b0;
    end else begin
      clr   = bus.wr_if ? val : '0;
      if_n  = (m_if & ~clr) | ev;
      m_irq = m_ime & (|(m_ie & m_if));
`ifdef GBA_IRQ_HALT_EN
      if (m_halt) m_halt = ~(|(m_ie & if_n));
      else        m_halt = bus.halt_req;
`endif
      if (bus.wr_ie) m_ie = (m_ie & ~msk) | val;
      if (bus.wr_ime && bus.wr_be[0]) m_ime = bus.wr_data[0];
      m_if   = if_n;
      m_prev = bus.irq_src;
      m_arm  = 1'b1;
    end
    e.if_v   = 16'(m_if);
    e.ie_v   = 16'(m_ie);
    e.ime_v  = {15'b0, m_ime};
    e.irq    = m_irq;
    e.halted = m_halt;
    sb_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_push();
    @(posedge clock_16);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      e = sb_q.pop_front();
      check_val("sb_IF",     bus.reg_IF,  e.if_v);
      check_val("sb_IE",     bus.reg_IE,  e.ie_v);
      check_val("sb_IME",    bus.reg_IME, e.ime_v);
      check_val("sb_irq",    16'(bus.irq),    16'(e.irq));
      check_val("sb_halted", 16'(bus.halted), 16'(e.halted));
    end
    bus.wr_ie    = 1'b0;
    bus.wr_if    = 1'b0;
    bus.wr_ime   = 1'b0;
    bus.halt_req = 1'b0;
  endtask

  task automatic write_reg(input logic [11:0] ofs, input logic [15:0] d, input logic [1:0] be);
    bus.wr_data = d;
    bus.wr_be   = be;
    bus.wr_ie   = (ofs == IRQ_IE_OFS);
    bus.wr_if   = (ofs == IRQ_IF_OFS);
    bus.wr_ime  = (ofs == IRQ_IME_OFS);
  endtask

  initial begin
    bus.irq_src  = '0;
    bus.wr_ie    = 1'b0;
    bus.wr_if    = 1'b0;
    bus.wr_ime   = 1'b0;
    bus.wr_data  = '0;
    bus.wr_be    = '0;
    bus.halt_req = 1'b0;

    reset = 1'b1;
    step(); step();
    check_val("rst_IF", bus.reg_IF, 16'h0000);
    check_val("rst_IE", bus.reg_IE, 16'h0000);
    check_val("rst_irq", 16'(bus.irq), 16'h0000);
    reset = 1'b0;

    // Timer 0 interrupt: IF at N+1, irq at N+2
    write_reg(IRQ_IE_OFS, 16'h0008, 2'b11); step();
    write_reg(IRQ_IME_OFS, 16'h0001, 2'b11); step();
    bus.irq_src = 14'h0008; step();
    check_val("t1_if", bus.reg_IF, 16'h0008);
    check_val("t1_irq_early", 16'(bus.irq), 16'h0000);
    bus.irq_src = '0; step();
    check_val("t1_irq", 16'(bus.irq), 16'h0001);

    // Acknowledge via write-1-to-clear
    write_reg(IRQ_IF_OFS, 16'h0008, 2'b11); step();
    check_val("t2_if", bus.reg_IF, 16'h0000);
    check_val("t2_irq_hold", 16'(bus.irq), 16'h0001);
    step();
    check_val("t2_irq", 16'(bus.irq), 16'h0000);

    // Same-cycle set and clear on bit 4, then byte-masked clears
    bus.irq_src = 14'h0010;
    write_reg(IRQ_IF_OFS, 16'h0010, 2'b11); step();
    check_val("t3_set_wins", bus.reg_IF, 16'h0010);
    bus.irq_src = '0;
    write_reg(IRQ_IF_OFS, 16'h0010, 2'b10); step();
    check_val("t3_be_hi", bus.reg_IF, 16'h0010);
    write_reg(IRQ_IF_OFS, 16'h0010, 2'b01); step();
    check_val("t3_be_lo", bus.reg_IF, 16'h0000);

    // IME gating
    write_reg(IRQ_IME_OFS, 16'h0000, 2'b11); step();
    write_reg(IRQ_IE_OFS, 16'h0001, 2'b11); step();
    bus.irq_src = 14'h0001; step();
    check_val("t4_if", bus.reg_IF, 16'h0001);
    bus.irq_src = '0; step(); step();
    check_val("t4_irq_off", 16'(bus.irq), 16'h0000);
    write_reg(IRQ_IME_OFS, 16'h0001, 2'b11); step();
    check_val("t4_ime_rd", bus.reg_IME, 16'h0001);
    check_val("t4_irq_w1", 16'(bus.irq), 16'h0000);
    step();
    check_val("t4_irq_w2", 16'(bus.irq), 16'h0001);

    // IE high byte only; bits 15:14 never read back
    write_reg(IRQ_IE_OFS, 16'hFFFF, 2'b10); step();
    check_val("ie_be_hi", bus.reg_IE, 16'h3F01);
    write_reg(IRQ_IE_OFS, 16'h0001, 2'b11); step();

    // All sources at once
    bus.irq_src = 14'h3FFF; step();
    check_val("multi_if", bus.reg_IF, 16'h3FFF);
    bus.irq_src = '0;
    write_reg(IRQ_IF_OFS, 16'hFFFF, 2'b11); step();
    check_val("multi_clr", bus.reg_IF, 16'h0000);

    // Source held high across reset release
    bus.irq_src = 14'h0020;
    reset = 1'b1; step();
    check_val("rst_mid_IE", bus.reg_IE, 16'h0000);
    check_val("rst_mid_IME", bus.reg_IME, 16'h0000);
    step();
    reset = 1'b0; step(); step(); step();
    check_val("t5_held", bus.reg_IF, 16'h0000);
    bus.irq_src = '0; step();
    bus.irq_src = 14'h0020; step();
    check_val("t5_edge", bus.reg_IF, 16'h0020);

    // Random traffic, scoreboard only
    for (int i = 0; i < 80; i++) begin
      int sel;
      bus.irq_src = NS'($urandom);
      sel = $urandom_range(0, 5);
      if (sel == 0) write_reg(IRQ_IE_OFS,  16'($urandom), 2'($urandom));
      if (sel == 1) write_reg(IRQ_IF_OFS,  16'($urandom), 2'($urandom));
      if (sel == 2) write_reg(IRQ_IME_OFS, 16'($urandom), 2'($urandom));
      bus.halt_req = ($urandom_range(0, 7) == 0);
      step();
    end

    bus.irq_src = '0;
    reset = 1'b1; step();
    reset = 1'b0; step();
`ifdef GBA_IRQ_HALT_EN
    write_reg(IRQ_IE_OFS, 16'h0040, 2'b11); step();
    bus.halt_req = 1'b1; step();
    check_val("t6_halted", 16'(bus.halted), 16'h0001);
    bus.halt_req = 1'b1; step();
    check_val("t6_halt_ign", 16'(bus.halted), 16'h0001);
    bus.irq_src = 14'h0040; step();
    check_val("t6_wake", 16'(bus.halted), 16'h0000);
    check_val("t6_if", bus.reg_IF, 16'h0040);
    bus.irq_src = '0; step();
    check_val("t6_irq", 16'(bus.irq), 16'h0000);
`else
    bus.halt_req = 1'b1; step();
    check_val("halt_off", 16'(bus.halted), 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
